// File: rtl/smoldvi_pattern_gen_if.sv
// Pixel stream bundle between the pattern source and its sink.
// master = pattern source, slave = pixel consumer.
interface smoldvi_pattern_gen_if #(
  parameter int W_COLOUR = 8,
  parameter int W_FRAME  = 8
);
  logic                en;
  logic [1:0]          mode;
  logic                rgb_rdy;
  logic [W_COLOUR-1:0] r;
  logic [W_COLOUR-1:0] g;
  logic [W_COLOUR-1:0] b;
  logic [9:0]          x;
  logic [8:0]          y;
  logic [W_FRAME-1:0]  frame_ctr;
  logic                sof;

  modport master (
    input  en, mode, rgb_rdy,
    output r, g, b, x, y, frame_ctr, sof
  );

  modport slave (
    output en, mode, rgb_rdy,
    input  r, g, b, x, y, frame_ctr, sof
  );
endinterface

// File: rtl/smoldvi_pattern_gen.sv
// DVI test-pattern source: raster tracker plus four patterns.
// Optional SMOLDVI_PATTERN_BORDER_EN paints a white frame border.
module smoldvi_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int PIX_REP  = 2,
  parameter int W_COLOUR = 8,
  parameter int W_FRAME  = 8
) (
  input logic clk_pix,
  input logic rst_pix,
  smoldvi_pattern_gen_if.master pix
);

  localparam int BW = H_ACTIVE / 8;
  localparam logic [9:0] X_STEP = 10'(PIX_REP);
  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - PIX_REP);
  localparam logic [8:0] Y_LAST = 9'(V_ACTIVE - 1);
  localparam logic [9:0] B_LAST = 10'(BW - PIX_REP);
  localparam logic [W_FRAME-1:0] F_ONE = W_FRAME'(1);
  localparam logic [W_COLOUR-1:0] F_ALL = '1;
  localparam logic [W_COLOUR-1:0] GREY =
    {1'b1, {(W_COLOUR-1){1'b0}}};

  logic [9:0]         x_q;
  logic [8:0]         y_q;
  logic [W_FRAME-1:0] fc_q;
  logic [1:0]         mode_q;
  logic [2:0]         bar_idx;
  logic [9:0]         bar_ctr;

  logic adv;
  logic last_x;
  logic last_y;
  logic [4:0] fc5;
  logic ck;

  assign adv    = pix.en & pix.rgb_rdy;
  assign last_x = (x_q == X_LAST);
  assign last_y = (y_q == Y_LAST);

  // Raster position, frame count, bar tracking and frame-aligned mode.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      x_q     <= '0;
      y_q     <= '0;
      fc_q    <= '0;
      mode_q  <= '0;
      bar_idx <= '0;
      bar_ctr <= '0;
    end else if (adv) begin
      if (last_x) begin
        x_q     <= '0;
        bar_idx <= '0;
        bar_ctr <= '0;
        if (last_y) begin
          y_q    <= '0;
          fc_q   <= fc_q + F_ONE;
          mode_q <= pix.mode;
        end else begin
          y_q <= y_q + 9'd1;
        end
      end else begin
        x_q <= x_q + X_STEP;
        if (bar_ctr == B_LAST) begin
          bar_ctr <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_ctr <= bar_ctr + X_STEP;
        end
      end
    end
  end

  assign fc5 = 5'(fc_q);
  assign ck  = 1'((x_q[5:0] + {fc5, 1'b0}) >> 5) ^ y_q[5];

  // Pattern select from registered state only.
  always_comb begin
    pix.r = '0;
    pix.g = '0;
    pix.b = '0;
    unique case (mode_q)
      2'd0: begin
        pix.r = W_COLOUR'(x_q) + W_COLOUR'(fc_q);
        pix.g = W_COLOUR'(y_q) + (W_COLOUR'(fc_q) << 1);
        pix.b = W_COLOUR'(fc_q);
      end
      2'd1: begin
        pix.r = {W_COLOUR{~bar_idx[1]}};
        pix.g = {W_COLOUR{~bar_idx[2]}};
        pix.b = {W_COLOUR{~bar_idx[0]}};
      end
      2'd2: begin
        pix.r = ck ? F_ALL : '0;
        pix.g = ck ? F_ALL : '0;
        pix.b = ck ? F_ALL : '0;
      end
      default: begin
        pix.r = GREY;
        pix.g = GREY;
        pix.b = GREY;
      end
    endcase
`ifdef SMOLDVI_PATTERN_BORDER_EN
    if (x_q == 10'd0 || last_x || y_q == 9'd0 || last_y) begin
      pix.r = F_ALL;
      pix.g = F_ALL;
      pix.b = F_ALL;
    end
`endif
  end

  assign pix.x         = x_q;
  assign pix.y         = y_q;
  assign pix.frame_ctr = fc_q;
  assign pix.sof       = (x_q == 10'd0) && (y_q == 9'd0);

endmodule

// File: tb/tb_smoldvi_pattern_gen.sv
// Directed bench for smoldvi_pattern_gen on a small 64x8 raster.
// Define SMOLDVI_PATTERN_BORDER_EN to expect the white border.
module tb_smoldvi_pattern_gen;

  localparam int H  = 64;
  localparam int V  = 8;
  localparam int PR = 2;
  localparam int LINE  = H / PR;
  localparam int FRAME = LINE * V;

`ifdef SMOLDVI_PATTERN_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic clk_pix = 1'b0;
  logic rst_pix;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_pix = ~clk_pix;

  smoldvi_pattern_gen_if #(.W_COLOUR(8), .W_FRAME(8)) pif ();

  smoldvi_pattern_gen #(
    .H_ACTIVE(H), .V_ACTIVE(V), .PIX_REP(PR),
    .W_COLOUR(8), .W_FRAME(8)
  ) dut (
    .clk_pix(clk_pix),
    .rst_pix(rst_pix),
    .pix(pif)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk_pix);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ep(input logic [7:0] v,
                                     input int px, input int py);
    if (BORDER && (px == 0 || px == H - PR || py == 0 || py == V - 1))
      return 32'hFF;
    return {24'd0, v};
  endfunction

  task automatic chk_rgb(input string tag, input int px, input int py,
                         input logic [7:0] er, input logic [7:0] eg,
                         input logic [7:0] eb);
    chk({tag, "_x"}, {22'd0, pif.x}, px);
    chk({tag, "_y"}, {23'd0, pif.y}, py);
    chk({tag, "_r"}, {24'd0, pif.r}, ep(er, px, py));
    chk({tag, "_g"}, {24'd0, pif.g}, ep(eg, px, py));
    chk({tag, "_b"}, {24'd0, pif.b}, ep(eb, px, py));
  endtask

  initial begin
    rst_pix   = 1'b1;
    pif.en    = 1'b0;
    pif.rgb_rdy = 1'b0;
    pif.mode  = 2'd0;
    step(2);
    rst_pix = 1'b0;
    step(1);
    chk("rst_fc", {24'd0, pif.frame_ctr}, 0);
    chk("rst_sof", {31'd0, pif.sof}, 1);
    chk_rgb("rst", 0, 0, 8'h00, 8'h00, 8'h00);

    pif.en = 1'b1;
    pif.rgb_rdy = 1'b1;
    step(1);
    chk("adv1_sof", {31'd0, pif.sof}, 0);
    chk_rgb("adv1", 2, 0, 8'h02, 8'h00, 8'h00);
    step(LINE - 1);
    chk("line_sof", {31'd0, pif.sof}, 0);
    chk_rgb("line", 0, 1, 8'h00, 8'h01, 8'h00);
    step(FRAME - LINE);
    chk("f1_fc", {24'd0, pif.frame_ctr}, 1);
    chk("f1_sof", {31'd0, pif.sof}, 1);
    chk_rgb("f1", 0, 0, 8'h01, 8'h02, 8'h01);

    step(10);
    pif.mode = 2'd1;
    step(1);
    chk_rgb("midmode", 22, 0, 8'h17, 8'h02, 8'h01);
    step(FRAME - 11);
    chk("f2_fc", {24'd0, pif.frame_ctr}, 2);
    chk_rgb("bar0", 0, 0, 8'hFF, 8'hFF, 8'hFF);
    pif.mode = 2'd0;
    step(4);
    chk_rgb("bar1", 8, 0, 8'hFF, 8'hFF, 8'h00);
    step(4);
    chk_rgb("bar2", 16, 0, 8'h00, 8'hFF, 8'hFF);
    step(20);
    chk_rgb("bar7", 56, 0, 8'h00, 8'h00, 8'h00);

    pif.rgb_rdy = 1'b0;
    step(1);
    chk("rdy0_x", {22'd0, pif.x}, 56);
    pif.rgb_rdy = 1'b1;
    step(1);
    chk("rdy1_x", {22'd0, pif.x}, 58);
    pif.en = 1'b0;
    step(10);
    chk("en0_x", {22'd0, pif.x}, 58);
    chk("en0_fc", {24'd0, pif.frame_ctr}, 2);
    pif.en = 1'b1;

    step(FRAME - 29);
    chk("f3_fc", {24'd0, pif.frame_ctr}, 3);
    chk_rgb("f3", 0, 0, 8'h03, 8'h06, 8'h03);
    step(252 * FRAME);
    chk("f255_fc", {24'd0, pif.frame_ctr}, 255);
    chk_rgb("f255", 0, 0, 8'hFF, 8'hFE, 8'hFF);
    pif.mode = 2'd2;
    step(FRAME);
    chk("wrap_fc", {24'd0, pif.frame_ctr}, 0);
    chk("wrap_sof", {31'd0, pif.sof}, 1);
    chk_rgb("ck0", 0, 0, 8'h00, 8'h00, 8'h00);
    step(16);
    chk_rgb("ck32", 32, 0, 8'hFF, 8'hFF, 8'hFF);

    pif.mode = 2'd3;
    step(FRAME - 16);
    step(5 * LINE);
    chk_rgb("grey_l", 0, 5, 8'h80, 8'h80, 8'h80);
    step(1);
    chk_rgb("grey_in", 2, 5, 8'h80, 8'h80, 8'h80);
    step(LINE - 2);
    chk_rgb("grey_r", H - PR, 5, 8'h80, 8'h80, 8'h80);

    rst_pix = 1'b1;
    step(1);
    rst_pix = 1'b0;
    chk("mrst_fc", {24'd0, pif.frame_ctr}, 0);
    chk("mrst_sof", {31'd0, pif.sof}, 1);
    chk_rgb("mrst", 0, 0, 8'h00, 8'h00, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
